// File: rtl/morse_keyer_q.sv
// -----------------------------------------------------------------------------
// morse_keyer_q
//
// Morse keyer for the button/LED encoder board. The red button steps a
// pending symbol index (A-Z, 0-9), blue queues it, and green aborts playback
// and flushes the queue. Queued symbols are keyed out on red_led with standard
// Morse timing taken from an internal code ROM.
//
// Parameters:
//   UNIT_CYCLES  clock cycles per Morse time unit (>= 2)
//   MAX_LEN      element slots per ROM entry (>= 5), patterns zero-extended
//   FIFO_DEPTH   queued characters (power of 2, >= 2)
//
// Optional feature macro: MORSE_WORD_GAP_EN
//   Defined   -> a character gap entered with an empty queue lasts 7 units.
//   Undefined -> the character gap is always 3 units.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-low reset
//   red_btn    in   rising edge: increment pending index (35 wraps to 0)
//   blue_btn   in   rising edge: enqueue pending index
//   green_btn  in   rising edge: abort playback, flush queue
//   sym_o      out  pending symbol index
//   fifo_level out  queued character count
//   red_led    out  key output, high during marks only
//   blue_led   out  busy, high whenever the FSM is not idle
//   green_led  out  queue full
//   dbg_state  out  current FSM state encoding
// -----------------------------------------------------------------------------
module morse_keyer_q #(
   parameter int UNIT_CYCLES = 8,
   parameter int MAX_LEN     = 5,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          red_btn,
   input  logic                          blue_btn,
   input  logic                          green_btn,
   output logic [5:0]                    sym_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          red_led,
   output logic                          blue_led,
   output logic                          green_led,
   output logic [2:0]                    dbg_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(7 * UNIT_CYCLES);

   localparam logic [TW-1:0] T_ONE   = TW'(UNIT_CYCLES - 1);
   localparam logic [TW-1:0] T_THREE = TW'(3 * UNIT_CYCLES - 1);
`ifdef MORSE_WORD_GAP_EN
   localparam logic [TW-1:0] T_SEVEN = TW'(7 * UNIT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MARK  = 3'd2,
      S_SPACE = 3'd3,
      S_CGAP  = 3'd4
   } state_t;

   // Handshake note: there is no valid/ready pair on this block. Button
   // events are single-cycle edge strobes (btn & ~prev) that act on the clock
   // edge that samples them; the queue accepts a push only when not full and
   // offers a pop only to the idle FSM, so producer and consumer never stall.

   // ---------------------------------------------------------------------------
   // Button edge detection
   // ---------------------------------------------------------------------------
   logic red_prev, blue_prev, green_prev;
   logic red_edge, blue_edge, green_edge;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         red_prev   <= 1'b0;
         blue_prev  <= 1'b0;
         green_prev <= 1'b0;
      end else begin
         red_prev   <= red_btn;
         blue_prev  <= blue_btn;
         green_prev <= green_btn;
      end
   end

   assign red_edge   = red_btn   & ~red_prev;
   assign blue_edge  = blue_btn  & ~blue_prev;
   assign green_edge = green_btn & ~green_prev;

   // ---------------------------------------------------------------------------
   // Pending symbol index. Green does not touch it. On a red+blue edge the
   // push below captures the old value because both use the registered index.
   // ---------------------------------------------------------------------------
   logic [5:0] sym_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sym_q <= 6'd0;
      end else if (red_edge) begin
         sym_q <= (sym_q == 6'd35) ? 6'd0 : sym_q + 6'd1;
      end
   end

   assign sym_o = sym_q;

   // ---------------------------------------------------------------------------
   // Character FIFO
   // ---------------------------------------------------------------------------
   state_t         state_q, state_d;
   logic [5:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [LW-1:0]  level_q;
   logic           fifo_full, fifo_empty;
   logic           push, pop;
   logic [5:0]     cur_sym;

   assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
   assign fifo_empty = (level_q == '0);

   // Green wins over everything: a coincident blue edge is discarded and no
   // pop is taken, the flush below empties the queue instead.
   assign push = blue_edge & ~fifo_full & ~green_edge;
   assign pop  = (state_q == S_IDLE) & ~fifo_empty & ~green_edge;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= sym_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else if (green_edge) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   assign fifo_level = level_q;
   assign green_led  = fifo_full;

   // ---------------------------------------------------------------------------
   // Code ROM: {len[2:0], pat[4:0]}, first element in bit 0, 1 = dash.
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] rom_entry(input logic [5:0] idx);
      case (idx)
         6'd0:    rom_entry = {3'd2, 5'b00010}; // A .-
         6'd1:    rom_entry = {3'd4, 5'b00001}; // B -...
         6'd2:    rom_entry = {3'd4, 5'b00101}; // C -.-.
         6'd3:    rom_entry = {3'd3, 5'b00001}; // D -..
         6'd4:    rom_entry = {3'd1, 5'b00000}; // E .
         6'd5:    rom_entry = {3'd4, 5'b00100}; // F ..-.
         6'd6:    rom_entry = {3'd3, 5'b00011}; // G --.
         6'd7:    rom_entry = {3'd4, 5'b00000}; // H ....
         6'd8:    rom_entry = {3'd2, 5'b00000}; // I ..
         6'd9:    rom_entry = {3'd4, 5'b01110}; // J .---
         6'd10:   rom_entry = {3'd3, 5'b00101}; // K -.-
         6'd11:   rom_entry = {3'd4, 5'b00010}; // L .-..
         6'd12:   rom_entry = {3'd2, 5'b00011}; // M --
         6'd13:   rom_entry = {3'd2, 5'b00001}; // N -.
         6'd14:   rom_entry = {3'd3, 5'b00111}; // O ---
         6'd15:   rom_entry = {3'd4, 5'b00110}; // P .--.
         6'd16:   rom_entry = {3'd4, 5'b01011}; // Q --.-
         6'd17:   rom_entry = {3'd3, 5'b00010}; // R .-.
         6'd18:   rom_entry = {3'd3, 5'b00000}; // S ...
         6'd19:   rom_entry = {3'd1, 5'b00001}; // T -
         6'd20:   rom_entry = {3'd3, 5'b00100}; // U ..-
         6'd21:   rom_entry = {3'd4, 5'b01000}; // V ...-
         6'd22:   rom_entry = {3'd3, 5'b00110}; // W .--
         6'd23:   rom_entry = {3'd4, 5'b01001}; // X -..-
         6'd24:   rom_entry = {3'd4, 5'b01101}; // Y -.--
         6'd25:   rom_entry = {3'd4, 5'b00011}; // Z --..
         6'd26:   rom_entry = {3'd5, 5'b11111}; // 0 -----
         6'd27:   rom_entry = {3'd5, 5'b11110}; // 1 .----
         6'd28:   rom_entry = {3'd5, 5'b11100}; // 2 ..---
         6'd29:   rom_entry = {3'd5, 5'b11000}; // 3 ...--
         6'd30:   rom_entry = {3'd5, 5'b10000}; // 4 ....-
         6'd31:   rom_entry = {3'd5, 5'b00000}; // 5 .....
         6'd32:   rom_entry = {3'd5, 5'b00001}; // 6 -....
         6'd33:   rom_entry = {3'd5, 5'b00011}; // 7 --...
         6'd34:   rom_entry = {3'd5, 5'b00111}; // 8 ---..
         6'd35:   rom_entry = {3'd5, 5'b01111}; // 9 ----.
         default: rom_entry = {3'd1, 5'b00000};
      endcase
   endfunction

   logic [7:0]         rom_word;
   logic [2:0]         rom_len;
   logic [MAX_LEN-1:0] rom_pat;

   assign rom_word = rom_entry(cur_sym);
   assign rom_len  = rom_word[7:5];
   assign rom_pat  = MAX_LEN'(rom_word[4:0]);

   // ---------------------------------------------------------------------------
   // Element sequencer
   // ---------------------------------------------------------------------------
   logic [MAX_LEN-1:0] pat_q;
   logic [2:0]         elem_cnt;
   logic [TW-1:0]      tmr_q;
   logic               tmr_load;
   logic [TW-1:0]      tmr_val;
   logic [TW-1:0]      gap_val;
   logic               tmr_done;

   assign tmr_done = (tmr_q == '0);

`ifdef MORSE_WORD_GAP_EN
   // Decided once at CGAP entry; a later push cannot shorten the loaded gap.
   assign gap_val = fifo_empty ? T_SEVEN : T_THREE;
`else
   assign gap_val = T_THREE;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and unit-timer load selection
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      if (green_edge) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
               state_d  = S_MARK;
               tmr_load = 1'b1;
               tmr_val  = rom_pat[0] ? T_THREE : T_ONE;
            end
            S_MARK: begin
               if (tmr_done) begin
                  tmr_load = 1'b1;
                  if (elem_cnt > 3'd1) begin
                     state_d = S_SPACE;
                     tmr_val = T_ONE;
                  end else begin
                     state_d = S_CGAP;
                     tmr_val = gap_val;
                  end
               end
            end
            S_SPACE: begin
               // pat_q was shifted on MARK exit, so bit 0 is the next element
               if (tmr_done) begin
                  state_d  = S_MARK;
                  tmr_load = 1'b1;
                  tmr_val  = pat_q[0] ? T_THREE : T_ONE;
               end
            end
            S_CGAP: begin
               if (tmr_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Datapath: popped symbol, element pattern/count and unit timer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_sym  <= 6'd0;
         pat_q    <= '0;
         elem_cnt <= 3'd0;
         tmr_q    <= '0;
      end else begin
         if (pop) cur_sym <= mem[rd_ptr];

         if (green_edge) begin
            tmr_q <= '0;
         end else if (tmr_load) begin
            tmr_q <= tmr_val;
         end else if (!tmr_done) begin
            tmr_q <= tmr_q - TW'(1);
         end

         if (!green_edge) begin
            if (state_q == S_LOAD) begin
               pat_q    <= rom_pat;
               elem_cnt <= rom_len;
            end else if (state_q == S_MARK && tmr_done) begin
               pat_q    <= pat_q >> 1;
               elem_cnt <= elem_cnt - 3'd1;
            end
         end
      end
   end

   // Outputs decoded from the state register only, so an async reset drops
   // the key immediately.
   always_comb begin
      red_led   = (state_q == S_MARK);
      blue_led  = (state_q != S_IDLE);
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_morse_keyer_q.sv
// -----------------------------------------------------------------------------
// tb_morse_keyer_q
//
// Directed bench for morse_keyer_q with UNIT_CYCLES = 4, FIFO_DEPTH = 4.
// A table of per-cycle blue-button vectors covers queue fill/overflow; hand
// sequences cover single-character timing, symbol stepping, abort and reset.
// -----------------------------------------------------------------------------
module tb_morse_keyer_q;

   localparam int U = 4;
`ifdef MORSE_WORD_GAP_EN
   localparam int GAP = 7 * U;
`else
   localparam int GAP = 3 * U;
`endif

   logic       clk;
   logic       rst;
   logic       red_btn, blue_btn, green_btn;
   logic [5:0] sym_o;
   logic [2:0] fifo_level;
   logic       red_led, blue_led, green_led;
   logic [2:0] dbg_state;

   morse_keyer_q #(
      .UNIT_CYCLES (U),
      .MAX_LEN     (5),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .red_btn    (red_btn),
      .blue_btn   (blue_btn),
      .green_btn  (green_btn),
      .sym_o      (sym_o),
      .fifo_level (fifo_level),
      .red_led    (red_led),
      .blue_led   (blue_led),
      .green_led  (green_led),
      .dbg_state  (dbg_state)
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ bookkeeping
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts key-down marks and busy-to-idle transitions (one per character).
   int   mark_cnt = 0;
   int   char_cnt = 0;
   logic red_prev_s = 1'b0;
   logic blue_prev_s = 1'b0;

   always @(negedge clk) begin
      if (red_led && !red_prev_s) mark_cnt++;
      if (!blue_led && blue_prev_s) char_cnt++;
      red_prev_s  = red_led;
      blue_prev_s = blue_led;
   end

   // -------------------------------------------------------------- vectors
   typedef struct {
      logic       blue;
      logic [2:0] exp_level;
      logic       exp_red;
      logic       exp_busy;
      logic       exp_full;
   } vec_t;

   vec_t tbl [17];

   initial begin
      int mark0, char0;

      // Six blue edges, one per 3 cycles, pending symbol F (..-.).
      tbl[0]  = '{1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 3'd1, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 3'd1, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 3'd1, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 3'd4, 1'b1, 1'b1, 1'b1};
      tbl[13] = '{1'b0, 3'd4, 1'b1, 1'b1, 1'b1};
      tbl[14] = '{1'b0, 3'd4, 1'b0, 1'b1, 1'b1};
      tbl[15] = '{1'b1, 3'd4, 1'b0, 1'b1, 1'b1};
      tbl[16] = '{1'b0, 3'd4, 1'b0, 1'b1, 1'b1};

      // ------------------------------------------------ 1: reset and idle
      rst = 1'b0;
      red_btn = 1'b0; blue_btn = 1'b0; green_btn = 1'b0;
      tick(); tick();
      check("reset_outputs", {sym_o, fifo_level, red_led, blue_led, green_led}, 12'd0);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_after_reset", {sym_o, fifo_level, red_led, blue_led, green_led}, 12'd0);
      end

      // ------------------------------------------------ 2: A (.-) timing
      blue_btn = 1'b1;
      tick();
      blue_btn = 1'b0;
      check("a_level_after_push", fifo_level, 3'd1);
      for (int k = 0; k < 24 + GAP + 4; k++) begin
         if (k > 0) tick();
         check("a_red", red_led, ((k >= 2 && k <= 5) || (k >= 10 && k <= 21)) ? 1 : 0);
         check("a_busy", blue_led, (k >= 1 && k < 22 + GAP) ? 1 : 0);
      end

      // ------------------------------------------------ 3: symbol stepping
      for (int i = 0; i < 36; i++) begin
         red_btn = 1'b1;
         tick();
         red_btn = 1'b0;
         check("sym_step", sym_o, (i + 1) % 36);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         red_btn = 1'b1; tick(); red_btn = 1'b0; tick();
      end
      check("sym_at_e", sym_o, 6'd4);
      red_btn = 1'b1; blue_btn = 1'b1;
      tick();
      red_btn = 1'b0; blue_btn = 1'b0;
      check("redblue_sym", sym_o, 6'd5);
      check("redblue_level", fifo_level, 3'd1);
      // E is one dot: high k=2..5, then straight into the character gap.
      for (int k = 1; k <= 6 + GAP; k++) begin
         tick();
         if (k == 2 || k == 5) check("e_red_high", red_led, 1'b1);
         if (k == 6) check("e_red_low", red_led, 1'b0);
         if (k == 5 + GAP) check("e_busy_end", blue_led, 1'b1);
         if (k == 6 + GAP) check("e_idle", blue_led, 1'b0);
      end
      tick(); tick();

      // ------------------------------------------------ 4: fill and overflow
      mark0 = mark_cnt;
      char0 = char_cnt;
      for (int i = 0; i < 17; i++) begin
         blue_btn = tbl[i].blue;
         tick();
         check($sformatf("tbl%0d_level", i), fifo_level, tbl[i].exp_level);
         check($sformatf("tbl%0d_red", i), red_led, tbl[i].exp_red);
         check($sformatf("tbl%0d_busy", i), blue_led, tbl[i].exp_busy);
         check($sformatf("tbl%0d_full", i), green_led, tbl[i].exp_full);
      end
      blue_btn = 1'b0;
      for (int i = 0; i < 300; i++) tick();
      check("fill_chars_played", char_cnt - char0, 5);
      check("fill_marks_played", mark_cnt - mark0, 20);
      check("fill_drained", fifo_level, 3'd0);
      check("fill_idle", blue_led, 1'b0);

      // ------------------------------------------------ 5: abort mid-dash
      for (int i = 0; i < 14; i++) begin
         red_btn = 1'b1; tick(); red_btn = 1'b0; tick();
      end
      check("sym_at_t", sym_o, 6'd19);
      blue_btn = 1'b1; tick();          // E0 push
      blue_btn = 1'b0; tick();          // E1 pop
      blue_btn = 1'b1; tick();          // E2 push, MARK
      blue_btn = 1'b0; tick();          // E3
      blue_btn = 1'b1; tick();          // E4 push
      blue_btn = 1'b0;
      check("abort_level_before", fifo_level, 3'd2);
      check("abort_red_before", red_led, 1'b1);
      tick(); tick(); tick();           // E5..E7, still inside the dash
      mark0 = mark_cnt;
      green_btn = 1'b1; tick();         // E8 green edge
      green_btn = 1'b0;
      check("abort_red", red_led, 1'b0);
      check("abort_busy", blue_led, 1'b0);
      check("abort_level", fifo_level, 3'd0);
      check("abort_full", green_led, 1'b0);
      check("abort_sym_kept", sym_o, 6'd19);
      tick();
      green_btn = 1'b1; blue_btn = 1'b1;
      tick();
      green_btn = 1'b0; blue_btn = 1'b0;
      check("green_blue_discard", fifo_level, 3'd0);
      for (int i = 0; i < 60; i++) tick();
      check("abort_no_marks", mark_cnt - mark0, 0);
      check("abort_still_idle", {red_led, blue_led}, 2'b00);

      // ------------------------------------------------ 6: T (one dash) gap
      blue_btn = 1'b1;
      tick();
      blue_btn = 1'b0;
      for (int k = 0; k < 14 + GAP + 3; k++) begin
         if (k > 0) tick();
         check("t_red", red_led, (k >= 2 && k <= 13) ? 1 : 0);
         check("t_busy", blue_led, (k >= 1 && k < 14 + GAP) ? 1 : 0);
      end

      // ------------------------------------------------ async reset mid-mark
      blue_btn = 1'b1; tick(); blue_btn = 1'b0;
      tick(); tick(); tick(); tick();
      check("rst_mid_red_before", red_led, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_red", red_led, 1'b0);
      check("rst_mid_busy", blue_led, 1'b0);
      check("rst_mid_sym", sym_o, 6'd0);
      tick();
      rst = 1'b1;
      tick();
      check("rst_release", {sym_o, fifo_level, red_led, blue_led, green_led}, 12'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/morse_keyer_q.md
# morse_keyer_q

Parametrised Morse keyer for the button/LED encoder board. Three buttons select a symbol (A–Z, 0–9), queue it, or abort. Queued symbols are played out on the red LED with standard Morse timing from an internal code ROM. It supersedes the fixed, untimed encoder by adding a character queue, a configurable time base and a proper element/gap state machine.

## Interface
- `UNIT_CYCLES`, 8: clock cycles per Morse time unit; must be ≥ 2.
- `MAX_LEN`, 5: element slots per ROM entry; must be ≥ 5; patterns are zero-extended.
- `FIFO_DEPTH`, 4: queued characters; must be a power of 2 and ≥ 2.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `red_btn`, in, 1: on a rising edge, increment the pending symbol index (wraps 35 → 0).
- `blue_btn`, in, 1: on a rising edge, enqueue the pending symbol index.
- `green_btn`, in, 1: on a rising edge, abort playback and flush the FIFO.
- `sym_o`, out, 6: pending symbol index (0–25 = A–Z, 26–35 = 0–9).
- `fifo_level`, out, $clog2(FIFO_DEPTH)+1: queued character count.
- `red_led`, out, 1: key output; high during dot/dash marks only.
- `blue_led`, out, 1: busy; high in every state except IDLE.
- `green_led`, out, 1: FIFO full.

## Operation
- **Buttons:** inputs arrive already synchronised and debounced. Each button has a registered previous value; an edge is `btn & ~prev`. Actions happen on the clock edge that samples the edge.
- **ROM:** 36 entries, each holding `len` (3 bits, 1–5) and `pat` (MAX_LEN bits). Elements play LSB first; 1 = dash, 0 = dot. Standard ITU codes, e.g. A: len 2, pat 0b10; 0: len 5, pat 0b11111.
- **FIFO:** FIFO_DEPTH × 6 bits.
  - Push on a blue edge when not full. Pushes while full are silently dropped.
  - Pop when the FSM is in IDLE and the FIFO is not empty.
  - Push and pop in the same cycle are both performed; the level is unchanged.
- **Simultaneous button edges:**
  - red + blue: the old index is enqueued, then the index increments.
  - green has priority over the FSM and the FIFO. The FIFO empties, state goes to IDLE, and the unit counter clears. Any blue edge in the same cycle is discarded. `sym_o` is not affected.
- **FSM states:**
  - IDLE → LOAD on pop.
  - LOAD (1 cycle): latch `pat`/`len`, set element counter = len, → MARK.
  - MARK: `red_led` = 1 for 1 unit (dot) or 3 units (dash). Decrement the element counter and shift `pat`. Then → SPACE if elements remain, else → CGAP.
  - SPACE: 1 unit, `red_led` = 0, → MARK.
  - CGAP: 3 units, `red_led` = 0, → IDLE.
- **Unit timer:** counter loads UNIT_CYCLES × n − 1 on state entry and counts down; the state exits when the counter is 0.
- **Reset values:** all LEDs 0, `sym_o` 0, `fifo_level` 0, state IDLE, button history 0. Reset mid-playback drops the key output immediately (asynchronously).

## Timing
- Blue edge sampled at clock edge E0 → `fifo_level` becomes 1 after E0.
- With the FSM idle: pop at E1 (state LOAD), MARK at E2. `red_led` is high from E2.
- A dot is exactly UNIT_CYCLES cycles high; a dash is 3 × UNIT_CYCLES.
- Inter-element gap is UNIT_CYCLES; inter-character gap is 3 × UNIT_CYCLES (before MORSE_WORD_GAP_EN is applied).
- Back-to-back queued characters: the next LOAD is the cycle after CGAP exits through IDLE, which adds 2 cycles of overhead per character.
- Green edge at E0 → `red_led`, `blue_led`, `green_led` and `fifo_level` are all 0 after E0.
- `green_led` and `fifo_level` update the same cycle as the push or pop.

## Configuration
- `MORSE_WORD_GAP_EN`
  - **Defined:** when CGAP is entered and the FIFO is empty, CGAP lasts 7 units (word gap) instead of 3. A push arriving during the extended gap does not shorten it.
  - **Undefined:** CGAP is always 3 units.

## Test plan
All scenarios use UNIT_CYCLES = 4 and FIFO_DEPTH = 4.

1. Reset asserted, then released → all LEDs 0, `sym_o` = 0, `fifo_level` = 0, and everything stays idle for 20 cycles.
2. Blue edge with `sym_o` = 0 (A) → `red_led` high 4 cycles starting 2 cycles after the push, low 4, high 12, then low. `blue_led` falls 12 cycles after the second mark ends (macro undefined).
3. 36 red edges → `sym_o` steps 0..35 and returns to 0. Red + blue edges in the same cycle at `sym_o` = 4 → E is queued and `sym_o` = 5.
4. Six blue edges, one per 3 cycles, starting idle → the first is popped, four are stored, the sixth is dropped. `green_led` = 1 while `fifo_level` = 4; exactly 5 characters are played.
5. Green edge mid-dash with 2 characters queued → next cycle: `red_led` = 0, `blue_led` = 0, `fifo_level` = 0. No further marks appear.
6. Macro defined, single T (one dash) queued → `blue_led` stays high 28 cycles after the dash ends. Macro undefined → 12 cycles.
